// File: rtl/pwm_pkg.sv
// Shared defaults and width helpers for the multi-channel PWM dimmer.
// Optional feature macro used by the dimmer top: PWM_MULTI_FADE_EN.
package pwm_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_PS_WIDTH = 8;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int dutyWidth(input int w);
    return w;
  endfunction

endpackage

// File: rtl/pwm_multi_dimmer_if.sv
// Control/write bus and PWM outputs of the multi-channel dimmer.
interface pwm_multi_dimmer_if #(
  parameter int WIDTH    = pwm_pkg::DEF_WIDTH,
  parameter int CHANNELS = pwm_pkg::DEF_CHANNELS,
  parameter int PS_WIDTH = pwm_pkg::DEF_PS_WIDTH
) ();
  import pwm_pkg::*;

  localparam int CH_W = chWidth(CHANNELS);
  localparam int DW   = dutyWidth(WIDTH);

  logic                en;
  logic [PS_WIDTH-1:0] prescale;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [DW-1:0]       wr_duty;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_tick;

  modport master (
    output en, prescale, wr_en, wr_ch, wr_duty,
    input  pwm_out, period_tick
  );

  modport slave (
    input  en, prescale, wr_en, wr_ch, wr_duty,
    output pwm_out, period_tick
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Prescaler: counts 0..prescale and strobes step on the terminal count.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic [PS_WIDTH-1:0] prescale_i,
  output logic                step_o
);

  logic [PS_WIDTH-1:0] cnt_q, cnt_d;

  // A counter left above a freshly lowered prescale wraps without a step.
  always_comb begin
    step_o = en_i && (cnt_q == prescale_i);
    cnt_d  = cnt_q + PS_WIDTH'(1);
    if (!en_i || (cnt_q >= prescale_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi_dimmer.sv
// Multi-channel PWM dimmer with shadow/active duty registers per channel.
// Define PWM_MULTI_FADE_EN to step active duties one LSB per period.
module pwm_multi_dimmer
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PS_WIDTH = DEF_PS_WIDTH
) (
  input logic               clk,
  input logic               reset,
  pwm_multi_dimmer_if.slave bus
);

  localparam int CH_W = chWidth(CHANNELS);
  localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  pwm_prescaler #(
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .en_i       (bus.en),
    .prescale_i (bus.prescale),
    .step_o     (step)
  );

  // Period spans 2^WIDTH-1 steps so that a full-scale duty is constantly high.
  always_comb begin
    boundary = step && (cnt_q == LAST_CNT);
    tick_d   = boundary;
    cnt_d    = cnt_q;
    if (!bus.en || boundary) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bus.period_tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;

    // Boundary copy samples shadow_q, so a coincident write lands a period later.
    always_comb begin
      shadow_d = shadow_q;
      if (bus.wr_en && (bus.wr_ch == IDX)) begin
        shadow_d = bus.wr_duty;
      end
      active_d = active_q;
      if (!bus.en) begin
        active_d = shadow_q;
      end else if (boundary) begin
`ifdef PWM_MULTI_FADE_EN
        if (active_q < shadow_q) begin
          active_d = active_q + WIDTH'(1);
        end else if (active_q > shadow_q) begin
          active_d = active_q - WIDTH'(1);
        end
`else
        active_d = shadow_q;
`endif
      end
      pwm_d = bus.en && (cnt_q < active_q);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign bus.pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_dimmer.sv
// Self-checking bench for pwm_multi_dimmer (WIDTH=4, CHANNELS=4, default build).
module tb_pwm_multi_dimmer;

  localparam int W  = 4;
  localparam int C  = 4;
  localparam int PS = 8;

  typedef struct packed {
    logic [15:0] duties;
    logic [7:0]  ps;
    logic [31:0] high;
    logic [15:0] len;
  } vec_t;

  typedef struct packed {
    logic [31:0] high;
    logic [15:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  pwm_multi_dimmer_if #(.WIDTH(W), .CHANNELS(C), .PS_WIDTH(PS)) bus ();

  pwm_multi_dimmer #(
    .WIDTH    (W),
    .CHANNELS (C),
    .PS_WIDTH (PS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input int duty);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_duty = 4'(duty);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pushExp(input int h0, input int h1, input int h2, input int h3, input int len);
    exp_t e;
    e.high = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
    e.len  = 16'(len);
    sb.push_back(e);
  endtask

  task automatic waitTick(input string name, input int budget, output int lat);
    bit found = 1'b0;
    lat = 0;
    while (!found && lat < budget) begin
      @(negedge clk);
      lat++;
      if (bus.period_tick) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no period_tick within %0d cycles", name, budget);
    end
  endtask

  // Window = cycles after one tick up to and including the next tick.
  task automatic measurePeriod(input string name, input int wrA, input int dA,
                               input int wrB, input int dB);
    int   high[4];
    int   len;
    bit   done;
    exp_t e;
    high = '{default: 0};
    len  = 0;
    done = 1'b0;
    while (!done && len < 1000) begin
      @(negedge clk);
      len++;
      for (int c = 0; c < 4; c++) if (bus.pwm_out[c]) high[c]++;
      if (bus.period_tick) done = 1'b1;
      bus.wr_en = 1'b0;
      if (len == wrA) begin
        bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_duty = 4'(dA);
      end
      if (len == wrB) begin
        bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_duty = 4'(dB);
      end
    end
    bus.wr_en = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no tick, expected a period end", name);
    end
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = sb.pop_front();
      for (int c = 0; c < 4; c++)
        checkOutput($sformatf("%s_high_ch%0d", name, c), high[c], int'(e.high[8*c +: 8]));
      checkOutput({name, "_len"}, len, int'(e.len));
    end
  endtask

  initial begin
    int lat;
    int bad;

    vecs[0] = '{duties: {4'd0, 4'd0, 4'd0, 4'd5},  ps: 8'd0,
                high: {8'd0, 8'd0, 8'd0, 8'd5},    len: 16'd15};
    vecs[1] = '{duties: {4'd8, 4'd15, 4'd0, 4'd5}, ps: 8'd0,
                high: {8'd8, 8'd15, 8'd0, 8'd5},   len: 16'd15};
    vecs[2] = '{duties: {4'd8, 4'd15, 4'd0, 4'd5}, ps: 8'd2,
                high: {8'd24, 8'd45, 8'd0, 8'd15}, len: 16'd45};
    vecs[3] = '{duties: {4'd3, 4'd7, 4'd14, 4'd1}, ps: 8'd1,
                high: {8'd6, 8'd14, 8'd28, 8'd2},  len: 16'd30};

    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.prescale = '0;
    bus.wr_en    = 1'b1;
    bus.wr_ch    = '0;
    bus.wr_duty  = 4'd9;
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_out", int'(bus.pwm_out), 0);
    checkOutput("reset_tick", int'(bus.period_tick), 0);
    bus.wr_en = 1'b0;
    reset     = 1'b0;

    waitTick("first_tick", 100, lat);
    checkOutput("first_tick_latency", lat, 15);

    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) applyStimulus(c, int'(vecs[k].duties[4*c +: 4]));
      bus.prescale = vecs[k].ps;
      sb.push_back('{high: vecs[k].high, len: vecs[k].len});
      waitTick($sformatf("vec%0d_sync1", k), 200, lat);
      waitTick($sformatf("vec%0d_sync2", k), 200, lat);
      measurePeriod($sformatf("vec%0d", k), -1, 0, -1, 0);
    end

    // Mid-period writes only take effect at the next boundary; last one wins.
    bus.prescale = '0;
    applyStimulus(0, 5);
    for (int c = 1; c < 4; c++) applyStimulus(c, 0);
    waitTick("mid_sync1", 200, lat);
    waitTick("mid_sync2", 200, lat);
    pushExp(5, 0, 0, 0, 15);
    pushExp(12, 0, 0, 0, 15);
    measurePeriod("mid_cur", 3, 10, 6, 12);
    measurePeriod("mid_next", -1, 0, -1, 0);

    // Write coincident with the boundary (counter 14 with a step).
    repeat (14) @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_duty = 4'd9;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checkOutput("coincident_tick_align", int'(bus.period_tick), 1);
    pushExp(12, 0, 0, 0, 15);
    pushExp(9, 0, 0, 0, 15);
    measurePeriod("coinc_p1", -1, 0, -1, 0);
    measurePeriod("coinc_p2", -1, 0, -1, 0);

    // Reset in the middle of a period.
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_ch0_high", int'(bus.pwm_out[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_pwm_out", int'(bus.pwm_out), 0);
    checkOutput("mid_reset_tick", int'(bus.period_tick), 0);
    reset = 1'b0;
    waitTick("post_reset_tick", 100, lat);
    checkOutput("post_reset_latency", lat, 15);
    pushExp(0, 0, 0, 0, 15);
    measurePeriod("post_reset", -1, 0, -1, 0);

    // Disabled: outputs and tick silent, writes still land in shadow.
    bus.en = 1'b0;
    applyStimulus(0, 7);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.pwm_out != '0 || bus.period_tick) bad++;
    end
    checkOutput("disabled_active_cycles", bad, 0);
    bus.en = 1'b1;
    waitTick("enable_tick", 100, lat);
    checkOutput("enable_latency", lat, 15);
    pushExp(7, 0, 0, 0, 15);
    measurePeriod("after_enable", -1, 0, -1, 0);

    if (sb.size() != 0) checkOutput("scoreboard_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi_dimmer.md
PWM_MULTI_DIMMER -- requirements
Module: pwm_multi_dimmer

Interface
REQ-001 Parameter WIDTH, 8, duty/counter resolution in bits (2..16).
REQ-002 Parameter CHANNELS, 4, number of independent PWM outputs (1..32).
REQ-003 Parameter PS_WIDTH, 8, prescaler compare width in bits.
REQ-004 Port clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port en  input  1  run enable; 0 = counters held, outputs low.
REQ-007 Port prescale  input  PS_WIDTH  counter advances once every prescale+1 clk cycles.
REQ-008 Port wr_en  input  1  single-cycle duty write strobe; always accepted, no back-pressure.
REQ-009 Port wr_ch  input  max(1,clog2(CHANNELS))  target channel of write.
REQ-010 Port wr_duty  input  WIDTH  new duty value, 0..2^WIDTH-1.
REQ-011 Port pwm_out  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-012 Port period_tick  output  1  registered one-cycle pulse at each period boundary.

Function
REQ-013 Prescaler counts 0..prescale; step strobe asserted the cycle it equals prescale, then it returns to 0; prescale=0 gives a step every cycle.
REQ-014 Period counter advances 0..MAX-1 on each step, MAX=2^WIDTH-1, wrapping MAX-1 -> 0; period = MAX steps.
REQ-015 Boundary = step while period counter is MAX-1; period_tick is 1 the cycle after the boundary, else 0.
REQ-016 pwm_out[i] = 1 iff period counter < active_duty[i], registered (1-cycle latency from counter).
REQ-017 Duty 0 -> output constantly 0; duty MAX -> constantly 1; no glitch pulses at either extreme.
REQ-018 Write with wr_en=1 and wr_ch<CHANNELS stores wr_duty into shadow[wr_ch] at the next edge; wr_ch>=CHANNELS ignored.
REQ-019 shadow copied to active for all channels only at a boundary; mid-period writes never alter the current period.
REQ-020 Write in the same cycle as a boundary: the copy uses the pre-write shadow; new value applies one period later.
REQ-021 Repeated writes to one channel within a period: last write wins.
REQ-022 en=0: prescaler and period counter held at 0, pwm_out=0, period_tick=0, writes still accepted, active=shadow every cycle.
REQ-023 en 0->1: counting starts from 0 with current active values; first boundary after MAX steps.
REQ-024 prescale change takes effect at the next prescaler comparison; if counter > new prescale it wraps to 0 on the next cycle.

Reset
REQ-025 reset=1 at a clk edge clears prescaler, period counter, all shadow and active duties, pwm_out, period_tick to 0, overriding en and wr_en.
REQ-026 Reset mid-period aborts the period; after release counting restarts from 0 with all duties 0.

Configuration
REQ-027 Macro PWM_MULTI_FADE_EN defined: at each boundary active[i] moves one LSB toward shadow[i] (unchanged if equal), giving linear fades.
REQ-028 PWM_MULTI_FADE_EN undefined: active[i] loads shadow[i] directly at each boundary (REQ-019); fade logic absent.
REQ-029 en=0 copy (REQ-022) is direct in both configurations.

Structure
REQ-030 Shared package pwm_pkg holds default WIDTH/CHANNELS/PS_WIDTH constants and the duty type width helper.
REQ-031 One sub-module, pwm_prescaler (prescale compare and step strobe); per-channel compare and duty registers stay in the top module as a generate loop.

Verification
REQ-032 WIDTH=4, CHANNELS=4, prescale=0, en=1, write ch0=5 -> after first boundary, ch0 high 5 of every 15 cycles; period_tick every 15 cycles.
REQ-033 Write ch1=0, ch2=15, ch3=8 -> ch1 constantly 0, ch2 constantly 1, ch3 high 8 of 15; prescale=2 -> period 45 cycles, ch3 high 24.
REQ-034 ch0=5 running, write ch0=10 at counter 3, then ch0=12 at counter 6 -> current period still 5 high; next period 12 high.
REQ-035 Write coincident with boundary -> new duty appears in the second following period; wr_ch=5 with CHANNELS=4 -> no channel changes.
REQ-036 PWM_MULTI_FADE_EN, active 0, write ch0=3 -> high times 1,2,3,3 over successive periods; then write 1 -> 2,1,1.
REQ-037 Reset asserted mid-period with ch0=5 -> next cycle all outputs 0, counters 0; en=0 -> outputs 0 and period_tick silent.
